leds_pwm: RTL
=============

# leds_pwm

Memory-mapped PWM LED controller that replaces the plain LED latch on the common memory bus, downstream of the address decoder. It holds per-channel 8-bit duty values and a global prescaler, and drives the board LED pins with glitch-free PWM. Duty changes take effect only at period boundaries. A sticky wrap flag lets software pace brightness updates.

## Interface
- `CHANNELS`, default 8: number of LED outputs; legal range 1..8. Unused duty bytes read 0 and ignore writes.
- `RESET_PRESCALE`, default 0: reset value of `CTRL.prescale`.

Ports:
- `clk`  in  1  system clock (PLL clock).
- `reset`  in  1  asynchronous, active-low reset.
- `address_in`  in  32  bus address; only bits [3:2] are decoded.
- `sel_in`  in  1  block select from the top-level decoder, window 0x0001_0000–0x0001_000F.
- `read_in`  in  1  read strobe.
- `read_value_out`  out  32  read data; 0 when `sel_in`=0.
- `write_mask_in`  in  4  byte-lane write enables.
- `write_value_in`  in  32  write data.
- `ready_out`  out  1  equals `sel_in`.
- `leds_out`  out  CHANNELS  PWM outputs, registered.

## Operation
Register map (word offsets):
- 0x0 CTRL: bit0 `enable`; bits [15:8] `prescale`. Other bits read 0.
- 0x4 DUTY_LO: byte *n* is the shadow duty for channel *n*, n=0..3.
- 0x8 DUTY_HI: byte *n* is the shadow duty for channel 4+*n*.
- 0xC STATUS: bit0 `wrap`, sticky, write-1-to-clear via lane 0; bits [15:8] current `cnt`, read-only.

Byte-lane rules: a field is written only when its lane's mask bit is set. Writes to read-only bits are ignored.

Timebase:
- `pre` counts 0..`prescale`. When `pre`==`prescale`, `pre` reloads to 0 and `cnt` advances.
- `cnt` counts 0..254 and wraps to 0, so one period is 255 ticks.

Period boundary (the tick where `cnt` goes 254→0):
- `wrap` is set.
- Each active duty is loaded from its shadow.

Output: `leds_out[i]` <= `enable` && (`cnt` < `active[i]`).
- Duty 0 is always off.
- Duty 255 is always on.

Disable (`enable`=0):
- `pre` and `cnt` are held at 0.
- `leds_out` is 0.
- Active duties track the shadows every cycle.
- `wrap` is not set.

Boundary conditions:
- A shadow write in the same cycle as a boundary: the active duty loads the old shadow; the new value applies from the next boundary.
- `wrap` set and W1C in the same cycle: set wins.
- A `prescale` write mid-period takes effect immediately. If the current `pre` already exceeds the new `prescale`, `pre` counts up to 255, wraps to 0, then resumes normal compare.
- Reset asserted mid-period: all state clears asynchronously; no partial period completes.

## Timing
- Reset values: `leds_out`=0, `read_value_out`=0, `enable`=0, `prescale`=`RESET_PRESCALE`, all duties=0, `wrap`=0, `cnt`=0, `pre`=0.
- Bus access is single-cycle: `ready_out`=`sel_in` combinationally; `read_value_out` is combinational from registers, gated by `sel_in`.
- Write data is captured at the `clk` edge where `sel_in`=1 and the mask bit is set.
- Output latency: one `clk` from the `cnt` update to `leds_out`.
- Period length: 255×(`prescale`+1) clocks.

## Configuration
- `LEDS_PWM_FADE_EN` defined: at each boundary, each active duty moves one step (±1) toward its shadow instead of jumping. A full 0→255 fade takes 255 periods. The disable path still copies shadows directly.
- Undefined: active duties load the shadow directly at the boundary; no fade logic is present.

## Structure
- Package `leds_pwm_pkg`:
  - register offset constants `CTRL_OFF`, `DUTY_LO_OFF`, `DUTY_HI_OFF`, `STATUS_OFF`;
  - CTRL bit-position constants;
  - `PERIOD_MAX`=8'd254;
  - a `duty_t` 8-bit typedef.
- Sub-module `pwm_timebase`: contains the prescaler and the `cnt` counter. Outputs `cnt`, a one-cycle `tick` pulse and a one-cycle `boundary` pulse.
- The top-level decoder widens the LED window to 16 bytes at 0x0001_0000.

## Test plan
- Reset then read all four registers → CTRL=0x0000_0000 (with `RESET_PRESCALE`=0), DUTY_LO/HI=0, STATUS=0, `leds_out`=0.
- CTRL=0x0000_0001, DUTY_LO=0x00FF_8000 → ch0 never high, ch1 high 128 of every 255 clocks, ch2 always high, ch3 low.
- CTRL prescale=3 with enable, DUTY_LO=0x0000_0040 → ch0 high 256 clocks of every 1020; STATUS.wrap sets every 1020 clocks; writing 0x1 to STATUS clears it.
- Write DUTY_LO byte 0 with mask 4'b0001 mid-period (20→200) → output keeps duty 20 until `cnt` wraps, then duty 200; other bytes unchanged.
- With `LEDS_PWM_FADE_EN`: shadow duty 0→10 while enabled → active duty reaches 10 after exactly 10 boundaries, monotonic.
- Assert `reset` low mid-period with ch0 high → `leds_out`=0 immediately (asynchronous); after release all registers read reset values.

Source files
------------

// File: rtl/leds_pwm_pkg.sv
// ============================================================================
// Module      : leds_pwm_pkg
// Description : Shared constants, duty type and fade helper for leds_pwm.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package leds_pwm_pkg;

    typedef logic [7:0] duty_t;

    // Register selectors are address bits [3:2], i.e. word index within the window
    localparam logic [1:0] CTRL_OFF    = 2'd0;
    localparam logic [1:0] DUTY_LO_OFF = 2'd1;
    localparam logic [1:0] DUTY_HI_OFF = 2'd2;
    localparam logic [1:0] STATUS_OFF  = 2'd3;

    localparam int CTRL_ENABLE_BIT   = 0;
    localparam int CTRL_PRESCALE_LSB = 8;
    localparam int CTRL_PRESCALE_MSB = 15;
    localparam int STATUS_WRAP_BIT   = 0;
    localparam int STATUS_CNT_LSB    = 8;
    localparam int STATUS_CNT_MSB    = 15;

    localparam duty_t PERIOD_MAX = 8'd254;

    function automatic duty_t fade_step(input duty_t cur, input duty_t tgt);
        duty_t res;
        res = cur;
        if (cur < tgt) begin
            res = cur + 8'd1;
        end else if (cur > tgt) begin
            res = cur - 8'd1;
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/leds_pwm_timebase.sv
// ============================================================================
// Module      : pwm_timebase
// Description : Prescaler plus 0..254 period counter with tick/boundary pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_timebase
    import leds_pwm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_enable,
    input  logic [7:0] i_prescale,
    output logic [7:0] o_cnt,
    output logic       o_tick,
    output logic       o_boundary
);

    logic [7:0] r_pre;
    logic [7:0] r_cnt;
    logic       w_tick;

    // Only equality reloads; a pre already above a newly lowered prescale
    // free-runs through 255 and wraps before matching again.
    assign w_tick     = i_enable && (r_pre == i_prescale);
    assign o_tick     = w_tick;
    assign o_boundary = w_tick && (r_cnt == PERIOD_MAX);
    assign o_cnt      = r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pre <= 8'd0;
            r_cnt <= 8'd0;
        end else if (!i_enable) begin
            r_pre <= 8'd0;
            r_cnt <= 8'd0;
        end else if (w_tick) begin
            r_pre <= 8'd0;
            r_cnt <= (r_cnt == PERIOD_MAX) ? 8'd0 : r_cnt + 8'd1;
        end else begin
            r_pre <= r_pre + 8'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/leds_pwm.sv
// ============================================================================
// Module      : leds_pwm
// Description : Memory-mapped PWM LED controller with shadowed per-channel duties.
//               Define LEDS_PWM_FADE_EN to step active duties +/-1 per period.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module leds_pwm
    import leds_pwm_pkg::*;
#(
    parameter int          CHANNELS       = 8,
    parameter logic [7:0]  RESET_PRESCALE = 8'd0
)(
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         address_in,
    input  logic                sel_in,
    input  logic                read_in,
    output logic [31:0]         read_value_out,
    input  logic [3:0]          write_mask_in,
    input  logic [31:0]         write_value_in,
    output logic                ready_out,
    output logic [CHANNELS-1:0] leds_out
);

    logic                r_enable;
    logic [7:0]          r_prescale;
    logic                r_wrap;
    logic [CHANNELS-1:0] r_leds;

    logic [7:0]          w_cnt;
    logic                w_tick;
    logic                w_boundary;
    logic                w_wr_ctrl;
    logic                w_wr_status;
    logic                w_wrap_clr;
    logic [63:0]         w_shadow_flat;
    logic [CHANNELS-1:0] w_led_on;
    logic [31:0]         w_rdata;
    logic                w_unused;

    assign w_unused = &{1'b0, read_in, address_in[31:4], address_in[1:0], w_tick};

    assign ready_out   = sel_in;
    assign w_wr_ctrl   = sel_in && (address_in[3:2] == CTRL_OFF);
    assign w_wr_status = sel_in && (address_in[3:2] == STATUS_OFF);
    assign w_wrap_clr  = w_wr_status && write_mask_in[0] && write_value_in[STATUS_WRAP_BIT];

    pwm_timebase u_timebase (
        .clk        (clk),
        .reset      (reset),
        .i_enable   (r_enable),
        .i_prescale (r_prescale),
        .o_cnt      (w_cnt),
        .o_tick     (w_tick),
        .o_boundary (w_boundary)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_enable   <= 1'b0;
            r_prescale <= RESET_PRESCALE;
        end else if (w_wr_ctrl) begin
            if (write_mask_in[0]) begin
                r_enable <= write_value_in[CTRL_ENABLE_BIT];
            end
            if (write_mask_in[1]) begin
                r_prescale <= write_value_in[CTRL_PRESCALE_MSB:CTRL_PRESCALE_LSB];
            end
        end
    end

    // Setting on a boundary outranks a simultaneous software clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrap <= 1'b0;
        end else if (w_boundary) begin
            r_wrap <= 1'b1;
        end else if (w_wrap_clr) begin
            r_wrap <= 1'b0;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        localparam logic [1:0] c_word = (i < 4) ? DUTY_LO_OFF : DUTY_HI_OFF;
        localparam int         c_lane = i % 4;

        duty_t r_shadow;
        duty_t r_active;
        logic  w_wr;

        assign w_wr = sel_in && (address_in[3:2] == c_word) && write_mask_in[c_lane];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_shadow <= 8'd0;
            end else if (w_wr) begin
                r_shadow <= write_value_in[8*c_lane +: 8];
            end
        end

        // Active sees the pre-write shadow on a boundary-coincident write
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_active <= 8'd0;
            end else if (!r_enable) begin
                r_active <= r_shadow;
            end else if (w_boundary) begin
`ifdef LEDS_PWM_FADE_EN
                r_active <= fade_step(r_active, r_shadow);
`else
                r_active <= r_shadow;
`endif
            end
        end

        assign w_led_on[i]             = r_enable && (w_cnt < r_active);
        assign w_shadow_flat[8*i +: 8] = r_shadow;
    end

    for (genvar j = CHANNELS; j < 8; j++) begin : g_pad
        assign w_shadow_flat[8*j +: 8] = 8'd0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_leds <= '0;
        end else begin
            r_leds <= w_led_on;
        end
    end

    assign leds_out = r_leds;

    always_comb begin
        w_rdata = 32'h0;
        case (address_in[3:2])
            CTRL_OFF: begin
                w_rdata[CTRL_ENABLE_BIT]                     = r_enable;
                w_rdata[CTRL_PRESCALE_MSB:CTRL_PRESCALE_LSB] = r_prescale;
            end
            DUTY_LO_OFF: w_rdata = w_shadow_flat[31:0];
            DUTY_HI_OFF: w_rdata = w_shadow_flat[63:32];
            default: begin
                w_rdata[STATUS_WRAP_BIT]               = r_wrap;
                w_rdata[STATUS_CNT_MSB:STATUS_CNT_LSB] = w_cnt;
            end
        endcase
    end

    assign read_value_out = sel_in ? w_rdata : 32'h0;

endmodule

`default_nettype wire
